// File: rtl/classify_ctrl_if.sv
// classify_ctrl_if: handshake bundle between the classification controller,
// its host (start / result side) and the row multiplier (launch / done_row side).
interface classify_ctrl_if;
    logic        start;
    logic [15:0] row_result;
    logic        overflow;
    logic        done_row;
    logic [3:0]  row_select;
    logic        begin_mult;
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [15:0] max_value;
    logic        error;

    // Environment side: requests classifications and models the multiplier.
    modport master (
        output start, row_result, overflow, done_row,
        input  row_select, begin_mult, busy, done, digit, max_value, error
    );

    // Controller side.
    modport slave (
        input  start, row_result, overflow, done_row,
        output row_select, begin_mult, busy, done, digit, max_value, error
    );
endinterface

// File: rtl/classify_ctrl.sv
// classify_ctrl: scores NUM_ROWS multiplier rows one at a time and reports the
// index and score of the highest row (ties keep the lower index). A row whose
// done_row never arrives within TIMEOUT_CYCLES aborts the run with error=1.
// Optional feature macro: CLASSIFY_SATURATE_EN -- when defined, a row reported
// with overflow=1 is scored as 16'hFFFF instead of its raw row_result.
module classify_ctrl #(
    parameter int NUM_ROWS       = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 n_rst,
    classify_ctrl_if.slave       bus
);

    localparam int         TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_WAIT_ROW = 3'd2,
        ST_COMPARE  = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_row_idx;
    logic [3:0]      w_row_idx_next;
    logic [TW-1:0]   r_timeout;
    logic [TW-1:0]   w_timeout_next;
    logic [15:0]     r_score;
    logic [15:0]     w_score_next;
    logic [3:0]      r_digit;
    logic [3:0]      w_digit_next;
    logic [15:0]     r_max_value;
    logic [15:0]     w_max_value_next;
    logic            r_error;
    logic            w_error_next;
    logic            r_begin_mult;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     w_capture;

`ifdef CLASSIFY_SATURATE_EN
    assign w_capture = bus.overflow ? 16'hFFFF : bus.row_result;
`else
    assign w_capture = bus.row_result;
`endif

    // Next-state and datapath update decode for the classification sequence.
    always_comb begin
        w_state_next     = r_state;
        w_row_idx_next   = r_row_idx;
        w_timeout_next   = r_timeout;
        w_score_next     = r_score;
        w_digit_next     = r_digit;
        w_max_value_next = r_max_value;
        w_error_next     = r_error;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_row_idx_next   = 4'd0;
                    w_digit_next     = 4'd0;
                    w_max_value_next = 16'd0;
                    w_error_next     = 1'b0;
                    w_state_next     = ST_LAUNCH;
                end else begin
                    w_state_next     = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                w_timeout_next = '0;
                w_state_next   = ST_WAIT_ROW;
            end
            ST_WAIT_ROW: begin
                if (bus.done_row) begin
                    w_score_next = w_capture;
                    w_state_next = ST_COMPARE;
                end else if (r_timeout == TO_LAST) begin
                    // Row never answered: abort, keep the best result so far.
                    w_error_next = 1'b1;
                    w_state_next = ST_FINISH;
                end else begin
                    w_timeout_next = r_timeout + TW'(1);
                end
            end
            ST_COMPARE: begin
                if ((r_row_idx == 4'd0) || (r_score > r_max_value)) begin
                    w_digit_next     = r_row_idx;
                    w_max_value_next = r_score;
                end else begin
                    w_digit_next     = r_digit;
                end
                if (r_row_idx == LAST_ROW) begin
                    w_state_next   = ST_FINISH;
                end else begin
                    w_row_idx_next = r_row_idx + 4'd1;
                    w_state_next   = ST_LAUNCH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs (decoded from next state).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_row_idx    <= 4'd0;
            r_timeout    <= '0;
            r_score      <= 16'd0;
            r_digit      <= 4'd0;
            r_max_value  <= 16'd0;
            r_error      <= 1'b0;
            r_begin_mult <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row_idx    <= w_row_idx_next;
            r_timeout    <= w_timeout_next;
            r_score      <= w_score_next;
            r_digit      <= w_digit_next;
            r_max_value  <= w_max_value_next;
            r_error      <= w_error_next;
            r_begin_mult <= (w_state_next == ST_LAUNCH);
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= (w_state_next == ST_FINISH);
        end
    end

    assign bus.row_select = r_row_idx;
    assign bus.begin_mult = r_begin_mult;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.digit      = r_digit;
    assign bus.max_value  = r_max_value;
    assign bus.error      = r_error;

endmodule

// File: doc/classify_ctrl.md
CLASSIFY_CTRL -- requirements
Module: classify_ctrl

Interface
REQ-001 Parameter NUM_ROWS, default 10, SHALL set the number of output rows scored per classification (legal 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, SHALL set the maximum number of WAIT_ROW cycles before done_row is declared missing.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request one classification; sampled only in IDLE.
REQ-006 row_result  input  16  SHALL be the unsigned dot-product of the current row, valid while done_row=1.
REQ-007 overflow  input  1  SHALL be the row-sum overflow bit, valid while done_row=1.
REQ-008 done_row  input  1  SHALL be the one-cycle row-complete strobe from the multiplier.
REQ-009 row_select  output  4  SHALL be the row index being scored.
REQ-010 begin_mult  output  1  SHALL be a one-cycle pulse launching the multiplier on row_select.
REQ-011 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-012 done  output  1  SHALL be a one-cycle pulse when a classification completes or aborts.
REQ-013 digit  output  4  SHALL be the index of the highest-scoring row.
REQ-014 max_value  output  16  SHALL be the score of that row.
REQ-015 error  output  1  SHALL flag a timeout abort of the most recent classification.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT_ROW, COMPARE, FINISH.
REQ-017 IDLE: start=1 SHALL clear row_idx, digit, max_value and error, then go to LAUNCH next cycle.
REQ-018 LAUNCH: begin_mult=1 for exactly one cycle, row_select=row_idx; next state WAIT_ROW with the timeout counter cleared.
REQ-019 row_select SHALL equal row_idx in every state, held stable from LAUNCH until COMPARE completes.
REQ-020 WAIT_ROW: done_row=1 SHALL capture the row score (see Configuration) into a holding register and go to COMPARE.
REQ-021 WAIT_ROW: each cycle without done_row SHALL increment the timeout counter; reaching TIMEOUT_CYCLES SHALL set error=1 and go to FINISH, leaving digit and max_value at their last values.
REQ-022 COMPARE: if row_idx=0 or the captured score is strictly greater than max_value, digit<=row_idx and max_value<=score; ties SHALL keep the lower index.
REQ-023 COMPARE: if row_idx=NUM_ROWS-1, go to FINISH; otherwise increment row_idx and go to LAUNCH.
REQ-024 FINISH: done=1 for one cycle, then IDLE; digit, max_value and error SHALL hold until the next accepted start.
REQ-025 start asserted outside IDLE SHALL be ignored; done_row outside WAIT_ROW SHALL be ignored.
REQ-026 Latency SHALL be 2 + 3*NUM_ROWS + sum of per-row wait cycles, from start sampled to done pulse.
REQ-027 All outputs SHALL be registered or decoded only from state and registers, with no combinational path from inputs.

Reset
REQ-028 n_rst=0 SHALL force IDLE, row_idx=0, row_select=0, begin_mult=0, busy=0, done=0, digit=0, max_value=0, error=0, and clear the timeout counter, including mid-classification.
REQ-029 After reset release, the first action SHALL be a start sampled in IDLE.

Configuration
REQ-030 Macro CLASSIFY_SATURATE_EN defined: the captured score SHALL be 16'hFFFF when overflow=1, else row_result.
REQ-031 Macro CLASSIFY_SATURATE_EN undefined: the captured score SHALL be row_result, and overflow SHALL be ignored.

Verification
REQ-032 Scores 10,50,30,...,0 for rows 0..9 -> digit=1, max_value=50, done pulses once, error=0.
REQ-033 Rows 3 and 7 both score 16'h1234 (the maximum) -> digit=3.
REQ-034 Row 5 returns row_result=16'h0010 with overflow=1, all other rows 16'h0100 -> with macro digit=5, max_value=16'hFFFF; without macro digit=0, max_value=16'h0100.
REQ-035 done_row withheld on row 4 -> done and error=1 after exactly 1023 WAIT_ROW cycles; digit and max_value hold rows 0..3 results.
REQ-036 n_rst pulsed during WAIT_ROW of row 6 -> all outputs reset; a new start then runs rows 0..9 with exactly 10 begin_mult pulses.
REQ-037 start held high through a whole classification -> begin_mult pulses only for rows 0..9 and no restart until FINISH returns to IDLE.
